// File: rtl/std_debouncer.sv
// std_debouncer: per-bit input conditioner feeding the edge detector.
// Each bit is optionally synchronised into i_clk, then passed on only after it has
// differed from the current debounced level for STABLE_CYCLES consecutive samples.
// Build option: define STD_DEBOUNCER_SYNC_EN to insert a 2-FF synchroniser per bit
// (needed for asynchronous pins). Without it i_signal must already be synchronous.

module std_debouncer #(
  parameter int unsigned BIT_WIDTH     = 1,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [BIT_WIDTH-1:0] i_signal,
  output logic [BIT_WIDTH-1:0] o_level,
  output logic [BIT_WIDTH-1:0] o_changed,
  output logic [BIT_WIDTH-1:0] o_busy
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  // Last count value before a differing sample is accepted.
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [BIT_WIDTH-1:0] LevelRst = {BIT_WIDTH{RESET_LEVEL}};

  logic [BIT_WIDTH-1:0] sample;

`ifdef STD_DEBOUNCER_SYNC_EN
  logic [BIT_WIDTH-1:0] sync1_q;
  logic [BIT_WIDTH-1:0] sync2_q;

  // Two-stage synchroniser; stages reset to the idle level so no spurious change appears.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= LevelRst;
      sync2_q <= LevelRst;
    end else begin
      sync1_q <= i_signal;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = i_signal;
`endif

  logic [CntW-1:0]      cnt_q [BIT_WIDTH];
  logic [CntW-1:0]      cnt_d [BIT_WIDTH];
  logic [BIT_WIDTH-1:0] level_q;
  logic [BIT_WIDTH-1:0] level_d;
  logic [BIT_WIDTH-1:0] changed_q;
  logic [BIT_WIDTH-1:0] changed_d;

  // Per-bit qualification: any sample matching the level restarts the count from zero.
  always_comb begin
    level_d   = level_q;
    changed_d = '0;
    for (int unsigned b = 0; b < BIT_WIDTH; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sample[b] == level_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CntMax) begin
        level_d[b]   = sample[b];
        changed_d[b] = 1'b1;
        cnt_d[b]     = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CntW'(1);
      end
    end
  end

  // Filter state; reset discards any in-flight qualification.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      level_q   <= LevelRst;
      changed_q <= '0;
      for (int unsigned b = 0; b < BIT_WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      level_q   <= level_d;
      changed_q <= changed_d;
      for (int unsigned b = 0; b < BIT_WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Busy flags come straight from the counter registers, so no path from i_signal.
  always_comb begin
    for (int unsigned b = 0; b < BIT_WIDTH; b++) begin
      o_busy[b] = (cnt_q[b] != '0);
    end
  end

  assign o_level   = level_q;
  assign o_changed = changed_q;

endmodule

// File: tb/tb_std_debouncer.sv
// Self-checking bench for std_debouncer (BIT_WIDTH=2, STABLE_CYCLES=4, RESET_LEVEL=0).
// Reference model: a delay queue for the synchroniser plus a window of recent samples;
// a bit flips when every sample in the window differs from its current level.

module tb_std_debouncer;

  localparam int unsigned BitWidth     = 2;
  localparam int unsigned StableCycles = 4;
`ifdef STD_DEBOUNCER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif
  // Edge offset (from the first edge seeing the new input) at which o_level updates.
  localparam int ExpLat = SyncLat + StableCycles - 1;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b0;
  logic [BitWidth-1:0] i_signal = '0;
  logic [BitWidth-1:0] o_level;
  logic [BitWidth-1:0] o_changed;
  logic [BitWidth-1:0] o_busy;

  std_debouncer #(
    .BIT_WIDTH    (BitWidth),
    .STABLE_CYCLES(StableCycles),
    .RESET_LEVEL  (1'b0)
  ) u_dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_signal (i_signal),
    .o_level  (o_level),
    .o_changed(o_changed),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [BitWidth-1:0] m_level;
  logic [BitWidth-1:0] m_changed;
  logic [BitWidth-1:0] m_busy;
  logic [BitWidth-1:0] pipe_q[$];
  logic [BitWidth-1:0] hist_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level   = '0;
    m_changed = '0;
    m_busy    = '0;
    pipe_q.delete();
    for (int i = 0; i < SyncLat; i++) pipe_q.push_back('0);
    hist_q.delete();
  endtask

  task automatic model_edge(input logic [BitWidth-1:0] in);
    logic [BitWidth-1:0] s;
    logic                all_diff;
    if (!i_reset) begin
      model_reset();
      return;
    end
    pipe_q.push_back(in);
    s = pipe_q.pop_front();
    hist_q.push_back(s);
    if (hist_q.size() > StableCycles) void'(hist_q.pop_front());
    m_changed = '0;
    for (int b = 0; b < BitWidth; b++) begin
      all_diff = (hist_q.size() == StableCycles);
      foreach (hist_q[j]) if (hist_q[j][b] == m_level[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[b]   = s[b];
        m_changed[b] = 1'b1;
      end
      m_busy[b] = (s[b] != m_level[b]);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".level"},   32'(o_level),   32'(m_level));
    check_eq({tag, ".changed"}, 32'(o_changed), 32'(m_changed));
    check_eq({tag, ".busy"},    32'(o_busy),    32'(m_busy));
  endtask

  // Drive a value, let one edge pass, update the model and compare 1 ns later.
  task automatic step(input logic [BitWidth-1:0] val);
    i_signal = val;
    @(posedge i_clk);
    model_edge(val);
    #1;
    check_outputs("model");
  endtask

  task automatic settle(input logic [BitWidth-1:0] val, input int n);
    repeat (n) step(val);
  endtask

  // Hold val and return the edge offset of the first o_changed pulse on bit_idx (-1: none).
  task automatic run_until_change(input int bit_idx, input logic [BitWidth-1:0] val,
                                  output int edge_idx);
    edge_idx = -1;
    for (int e = 0; e < 30; e++) begin
      step(val);
      if (o_changed[bit_idx]) begin
        edge_idx = e;
        break;
      end
    end
  endtask

  initial begin
    int             e_idx;
    int             first0;
    int             first1;
    int             pulses;
    int             hold;
    logic [BitWidth-1:0] cur;
    logic           pat [12];
    logic [BitWidth-1:0] v;

    // Reset state.
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    settle(2'b00, 3);

    // Clean step on bit 0.
    run_until_change(0, 2'b01, e_idx);
    check_eq("clean_step_latency", 32'(e_idx), 32'(ExpLat));
    check_eq("clean_step_level", 32'(o_level), 32'(2'b01));
    settle(2'b01, 6);

    // Rise then fall on bit 1.
    run_until_change(1, 2'b11, e_idx);
    check_eq("bit1_rise_latency", 32'(e_idx), 32'(ExpLat));
    settle(2'b11, 6);
    run_until_change(1, 2'b01, e_idx);
    check_eq("bit1_fall_latency", 32'(e_idx), 32'(ExpLat));
    check_eq("bit1_fall_level", 32'(o_level[1]), 32'(0));
    settle(2'b00, 10);

    // Bounce: 1,1,1,0 then steady 1 restarts qualification at the 0.
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    first0 = -1;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      v = {1'b0, pat[e]};
      step(v);
      if (o_changed[0]) begin
        pulses++;
        if (first0 < 0) first0 = e;
      end
    end
    check_eq("bounce_latency", 32'(first0), 32'(4 + ExpLat));
    check_eq("bounce_pulses", 32'(pulses), 32'(1));
    settle(2'b00, 10);

    // Independent bits: bit0 at k, bit1 at k+2.
    first0 = -1;
    first1 = -1;
    for (int e = 0; e < 14; e++) begin
      v = {logic'(e >= 2), 1'b1};
      step(v);
      if (o_changed[0] && first0 < 0) first0 = e;
      if (o_changed[1] && first1 < 0) first1 = e;
    end
    check_eq("indep_bit0", 32'(first0), 32'(ExpLat));
    check_eq("indep_bit1", 32'(first1), 32'(2 + ExpLat));
    settle(2'b00, 10);

    // Asynchronous reset while bit 0's counter is at 2.
    settle(2'b01, SyncLat + 2);
    check_eq("pre_reset_busy", 32'(o_busy), 32'(2'b01));
    #2;
    i_reset = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    settle(2'b01, 3);
    @(negedge i_clk);
    i_reset = 1'b1;
    run_until_change(0, 2'b01, e_idx);
    check_eq("post_reset_latency", 32'(e_idx), 32'(ExpLat));

    // Randomised bouncing inputs with variable hold times, plus one mid-run reset.
    cur  = '0;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        cur  = BitWidth'($urandom);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3);
      end else begin
        hold--;
      end
      step(cur);
      if (c == 700) begin
        #3;
        i_reset = 1'b0;
        model_reset();
        #1;
        check_outputs("rand_reset");
        @(negedge i_clk);
        i_reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/std_debouncer.md
# std_debouncer

Per-bit input conditioner placed directly upstream of the team's simple edge detector. It synchronises each asynchronous input bit into `i_clk`, then filters it so that only a level held stable for `STABLE_CYCLES` consecutive samples is passed on. Its `o_level` output is the glitch-free, clock-domain-safe signal the edge detector expects on its `i_signal` input. It also produces registered per-bit change strobes and busy flags for consumers that need them.

## Interface
- `BIT_WIDTH`, default 1: number of independent input bits; each bit has its own filter.
- `STABLE_CYCLES`, default 16: consecutive differing samples required to accept a new level; must be ≥ 1.
- `RESET_LEVEL`, default 1'b0: value loaded into `o_level` and into all synchroniser stages at reset, replicated to every bit.
- `i_clk`, input, 1: single clock; all logic on posedge.
- `i_reset`, input, 1: asynchronous, active-low reset.
- `i_signal`, input, BIT_WIDTH: raw, possibly asynchronous and bouncing inputs.
- `o_level`, output, BIT_WIDTH: debounced level, registered.
- `o_changed`, output, BIT_WIDTH: one-cycle pulse, registered, high in the cycle `o_level` takes a new value.
- `o_busy`, output, BIT_WIDTH: high while that bit's counter is non-zero, meaning a candidate change is being qualified.

## Operation
- Sample `s[i]`:
  - With the synchroniser compiled in, `s[i]` is the output of a 2-FF chain.
  - Without it, `s[i]` is `i_signal[i]` directly.
- Counter `cnt[i]`, width `$clog2(STABLE_CYCLES+1)`, one per bit. Each posedge:
  - `s[i] == o_level[i]`: `cnt[i]` ← 0. `o_changed[i]` ← 0.
  - `s[i] != o_level[i]` and `cnt[i] < STABLE_CYCLES-1`: `cnt[i]` ← `cnt[i]+1`. `o_changed[i]` ← 0.
  - `s[i] != o_level[i]` and `cnt[i] == STABLE_CYCLES-1`: `o_level[i]` ← `s[i]`, `cnt[i]` ← 0, `o_changed[i]` ← 1.
- `o_busy[i]` = (`cnt[i]` != 0). It is derived from the register, so no combinational path exists from `i_signal`.
- Any single sample equal to `o_level` restarts qualification from 0. There is no partial credit.
- Bits are fully independent. Simultaneous changes on several bits are each qualified on their own.
- `STABLE_CYCLES` == 1: the first differing sample is accepted on that same edge. `o_busy` stays 0.
- Counter never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.
- Reset (asynchronous, any time including mid-qualification):
  - `o_level` = `RESET_LEVEL`.
  - `o_changed` = 0, `o_busy` = 0, all `cnt` = 0.
  - Synchroniser stages = `RESET_LEVEL`.
  - In-flight qualification is discarded.
- After reset release, an input that already differs from `RESET_LEVEL` is qualified normally. `o_changed` pulses when it is accepted.

## Timing
- Input changes before posedge k and then holds.
- With the synchroniser: `o_level` and `o_changed` update on posedge k+STABLE_CYCLES+1.
- Without the synchroniser: they update on posedge k+STABLE_CYCLES-1.
- `o_changed` is high for exactly one cycle per accepted change. Back-to-back accepted changes on one bit are at least `STABLE_CYCLES` cycles apart.
- All outputs are registered, with zero combinational input-to-output paths.

## Configuration
- Macro `STD_DEBOUNCER_SYNC_EN`.
  - Defined: 2-FF synchroniser per bit, reset to `RESET_LEVEL`. Use this for asynchronous pins.
  - Undefined: no synchroniser, and latency shrinks by 2 cycles. Use this only when `i_signal` is already synchronous to `i_clk`.

## Test plan
All scenarios use `BIT_WIDTH`=2, `STABLE_CYCLES`=4, `RESET_LEVEL`=0, `STD_DEBOUNCER_SYNC_EN` defined.
- Clean step: `i_signal[0]` 0→1 before edge k.
  - `o_level[0]`=1 and `o_changed[0]`=1 at edge k+5 only.
  - `o_busy[0]` high from edge k+2 through edge k+4.
- Bounce: `i_signal[0]` pattern 1,1,1,0,1,1,1,1 from edge k.
  - Counter restarts at the 0.
  - `o_level[0]` rises at edge k+9, with a single `o_changed` pulse.
- Independent bits: bit0 goes high at k, bit1 at k+2.
  - `o_changed[0]` at k+5, `o_changed[1]` at k+7.
  - No cross-interaction.
- Reset mid-qualification: assert `i_reset`=0 asynchronously while `cnt`=2.
  - All outputs go to 0 immediately.
  - After release with input held at 1, `o_level` rises at release edge +5.
- Falling edge: after `o_level[1]`=1, drive `i_signal[1]`=0 at k.
  - `o_level[1]`=0 and `o_changed[1]`=1 at k+5.
- Rebuild with macro undefined, clean step at k.
  - `o_level[0]` rises at k+3.
